// File: rtl/tpu_host_ctrl_if.sv
// ---------------------------------------------------------------------------
// tpu_host_ctrl_if
//   Bundles every handshake and bus signal of the TPU host controller:
//   command stream (cmd_*), load stream (ld_*), result stream (res_*),
//   error pulse, TPU launch/busy handshake, A/B buffer write ports and the
//   C buffer read port.
//   slave  : the controller itself (tpu_host_ctrl)
//   master : the surrounding fabric (host, TPU, buffers)
// ---------------------------------------------------------------------------
interface tpu_host_ctrl_if #(
  parameter int IDX_W = 16,
  parameter int AB_W  = 32,
  parameter int C_W   = 128
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_k;
  logic [7:0]       cmd_m;
  logic [7:0]       cmd_n;
  logic             ld_valid;
  logic             ld_ready;
  logic [AB_W-1:0]  ld_a;
  logic [AB_W-1:0]  ld_b;
  logic             res_valid;
  logic             res_ready;
  logic [C_W-1:0]   res_data;
  logic             res_last;
  logic             err;
  logic             tpu_in_valid;
  logic [7:0]       tpu_K;
  logic [7:0]       tpu_M;
  logic [7:0]       tpu_N;
  logic             tpu_busy;
  logic             host_own;
  logic             a_wr_en;
  logic             b_wr_en;
  logic [IDX_W-1:0] a_index;
  logic [IDX_W-1:0] b_index;
  logic [AB_W-1:0]  a_data_in;
  logic [AB_W-1:0]  b_data_in;
  logic [IDX_W-1:0] c_index;
  logic [C_W-1:0]   c_data_out;

  modport slave (
    input  cmd_valid, cmd_k, cmd_m, cmd_n, ld_valid, ld_a, ld_b, res_ready,
           tpu_busy, c_data_out,
    output cmd_ready, ld_ready, res_valid, res_data, res_last, err,
           tpu_in_valid, tpu_K, tpu_M, tpu_N, host_own, a_wr_en, b_wr_en,
           a_index, b_index, a_data_in, b_data_in, c_index
  );

  modport master (
    output cmd_valid, cmd_k, cmd_m, cmd_n, ld_valid, ld_a, ld_b, res_ready,
           tpu_busy, c_data_out,
    input  cmd_ready, ld_ready, res_valid, res_data, res_last, err,
           tpu_in_valid, tpu_K, tpu_M, tpu_N, host_own, a_wr_en, b_wr_en,
           a_index, b_index, a_data_in, b_data_in, c_index
  );
endinterface

// File: rtl/tpu_host_ctrl.sv
// ---------------------------------------------------------------------------
// tpu_host_ctrl
//   Host-side initiator for the 4x4 systolic TPU. Accepts a command (K/M/N),
//   streams K load beats into the A/B buffers, pulses the TPU launch, waits
//   for the busy handshake, then reads the four C rows back onto the result
//   stream.
// Ports
//   clk  : clock
//   rst  : synchronous reset, active high
//   bus  : tpu_host_ctrl_if.slave (command / load / result streams, err,
//          TPU launch + busy, A/B write ports, C read port)
// ---------------------------------------------------------------------------
module tpu_host_ctrl #(
  parameter int IDX_W  = 16,
  parameter int AB_W   = 32,
  parameter int C_W    = 128,
  parameter int TO_CYC = 16
) (
  input logic            clk,
  input logic            rst,
  tpu_host_ctrl_if.slave bus
);

  localparam int TMO_W = $clog2(TO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAITB  = 3'd3,
    S_RUN    = 3'd4,
    S_UNLOAD = 3'd5
  } state_t;

  // Per-row unload phases: RD presents the address, CAP captures the
  // buffer data one cycle later, HOLD presents the row until accepted.
  typedef enum logic [1:0] {
    P_RD   = 2'd0,
    P_CAP  = 2'd1,
    P_HOLD = 2'd2
  } phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [7:0]       kc_q, kc_d;
  logic [1:0]       row_q, row_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       k_q, k_d, m_q, m_d, n_q, n_d;
  logic [C_W-1:0]   res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             res_last_q, res_last_d;
  logic             err_q, err_d;

  logic             cmd_ready;
  logic             ld_ready;
  logic             wr_en;
  logic [IDX_W-1:0] wr_index;
  logic [AB_W-1:0]  a_wdata;
  logic [AB_W-1:0]  b_wdata;
  logic             tpu_in_valid;
  logic             host_own;
  logic [IDX_W-1:0] c_index;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= P_RD;
      kc_q        <= 8'd0;
      row_q       <= 2'd0;
      tmo_q       <= {TMO_W{1'b0}};
      k_q         <= 8'd0;
      m_q         <= 8'd0;
      n_q         <= 8'd0;
      res_data_q  <= {C_W{1'b0}};
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      kc_q        <= kc_d;
      row_q       <= row_d;
      tmo_q       <= tmo_d;
      k_q         <= k_d;
      m_q         <= m_d;
      n_q         <= n_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    kc_d        = kc_q;
    row_d       = row_q;
    tmo_d       = tmo_q;
    k_d         = k_q;
    m_d         = m_q;
    n_d         = n_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_last_d  = res_last_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          k_d = bus.cmd_k;
          m_d = bus.cmd_m;
          n_d = bus.cmd_n;
          // A zero-step matmul is rejected without touching the buffers.
          if (bus.cmd_k == 8'd0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            kc_d    = 8'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (bus.ld_valid) begin
          kc_d = kc_q + 8'd1;
          if (kc_q == (k_q - 8'd1)) begin
            state_d = S_LAUNCH;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          kc_d = kc_q;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAITB;
        tmo_d   = {TMO_W{1'b0}};
      end
      S_WAITB: begin
        if (bus.tpu_busy) begin
          state_d = S_RUN;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      S_RUN: begin
        if (!bus.tpu_busy) begin
          state_d = S_UNLOAD;
          row_d   = 2'd0;
          phase_d = P_RD;
        end else begin
          state_d = S_RUN;
        end
      end
      S_UNLOAD: begin
        case (phase_q)
          P_RD: begin
            phase_d = P_CAP;
          end
          P_CAP: begin
            res_data_d  = bus.c_data_out;
            res_valid_d = 1'b1;
            res_last_d  = (row_q == 2'd3);
            phase_d     = P_HOLD;
          end
          P_HOLD: begin
            if (res_valid_q && bus.res_ready) begin
              res_valid_d = 1'b0;
              res_last_d  = 1'b0;
              if (row_q == 2'd3) begin
                state_d = S_IDLE;
                phase_d = P_RD;
              end else begin
                // Next row address was already presented during HOLD,
                // so its data is ready to capture right away.
                row_d   = row_q + 2'd1;
                phase_d = P_CAP;
              end
            end else begin
              phase_d = P_HOLD;
            end
          end
          default: begin
            phase_d = P_RD;
          end
        endcase
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Combinational FSM outputs: handshakes, buffer ports and launch pulse.
  always_comb begin
    cmd_ready    = 1'b0;
    ld_ready     = 1'b0;
    wr_en        = 1'b0;
    wr_index     = {IDX_W{1'b0}};
    a_wdata      = {AB_W{1'b0}};
    b_wdata      = {AB_W{1'b0}};
    tpu_in_valid = 1'b0;
    host_own     = 1'b1;
    c_index      = {IDX_W{1'b0}};
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (bus.ld_valid) begin
          wr_en    = 1'b1;
          wr_index = IDX_W'(kc_q);
          a_wdata  = bus.ld_a;
          b_wdata  = bus.ld_b;
        end else begin
          wr_en = 1'b0;
        end
      end
      S_LAUNCH: begin
        tpu_in_valid = 1'b1;
        host_own     = 1'b0;
      end
      S_WAITB: begin
        host_own = 1'b0;
      end
      S_RUN: begin
        host_own = 1'b0;
      end
      S_UNLOAD: begin
        // While a row is held, prefetch the next row's address.
        if (phase_q == P_HOLD) begin
          c_index = IDX_W'(row_q + 2'd1);
        end else begin
          c_index = IDX_W'(row_q);
        end
      end
      default: begin
        host_own = 1'b1;
      end
    endcase
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.ld_ready     = ld_ready;
  assign bus.a_wr_en      = wr_en;
  assign bus.b_wr_en      = wr_en;
  assign bus.a_index      = wr_index;
  assign bus.b_index      = wr_index;
  assign bus.a_data_in    = a_wdata;
  assign bus.b_data_in    = b_wdata;
  assign bus.tpu_in_valid = tpu_in_valid;
  assign bus.host_own     = host_own;
  assign bus.c_index      = c_index;
  assign bus.tpu_K        = k_q;
  assign bus.tpu_M        = m_q;
  assign bus.tpu_N        = n_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_last     = res_last_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_tpu_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tpu_host_ctrl
//   Directed bench for tpu_host_ctrl with a small TPU model (busy for 14
//   cycles after launch, C = A*B computed from the words written into the
//   A/B buffers) and a one-cycle-latency C buffer.
// ---------------------------------------------------------------------------
module tb_tpu_host_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_host_ctrl_if #(.IDX_W(16), .AB_W(32), .C_W(128)) bus();

  tpu_host_ctrl #(.IDX_W(16), .AB_W(32), .C_W(128), .TO_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0]  amem [0:255];
  logic [31:0]  bmem [0:255];
  logic [127:0] cmem [0:3];
  logic [127:0] c_rd = 128'd0;
  logic [127:0] exp_row [0:3];
  int busy_cnt = 0;
  int wr_cnt   = 0;
  int inv_cnt  = 0;
  bit tpu_en   = 1'b1;

  function automatic logic [127:0] calc_row(input int i, input int kk);
    logic [127:0] r;
    int s;
    r = 128'd0;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int k = 0; k < kk; k++) begin
        s = s + $signed(amem[k][31-8*i -: 8]) * $signed(bmem[k][31-8*j -: 8]);
      end
      r[127-32*j -: 32] = s;
    end
    return r;
  endfunction

  // A/B buffer capture and event counting.
  always @(posedge clk) begin
    if (bus.a_wr_en) amem[bus.a_index[7:0]] <= bus.a_data_in;
    if (bus.b_wr_en) bmem[bus.b_index[7:0]] <= bus.b_data_in;
    if (bus.a_wr_en || bus.b_wr_en) wr_cnt <= wr_cnt + 1;
    if (bus.tpu_in_valid) inv_cnt <= inv_cnt + 1;
  end

  // TPU model: latch C at launch, stay busy for 14 cycles.
  always @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 0;
    end else if (bus.tpu_in_valid && tpu_en) begin
      busy_cnt <= 14;
      for (int i = 0; i < 4; i++) cmem[i] <= calc_row(i, int'(bus.tpu_K));
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // C buffer read port, one cycle latency.
  always @(posedge clk) begin
    c_rd <= (bus.c_index < 16'd4) ? cmem[bus.c_index[1:0]] : 128'd0;
  end

  assign bus.c_data_out = c_rd;
  assign bus.tpu_busy   = (busy_cnt != 0);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_cmd(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_k = k;
    bus.cmd_m = m;
    bus.cmd_n = n;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load_beats(input int cnt, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < cnt; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_a = a;
      bus.ld_b = b;
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic wait_res(output bit ok);
    int cnt;
    ok = 1'b0;
    cnt = 0;
    while (!ok && cnt < 200) begin
      @(negedge clk); #1;
      if (bus.res_valid) ok = 1'b1;
      cnt++;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int cnt;
    ok = 1'b0;
    cnt = 0;
    while (!ok && cnt < 200) begin
      @(negedge clk); #1;
      if (bus.cmd_ready) ok = 1'b1;
      cnt++;
    end
  endtask

  task automatic test_reset;
    logic [8:0] fl;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    fl = {bus.cmd_ready, bus.ld_ready, bus.host_own, bus.a_wr_en, bus.b_wr_en,
          bus.tpu_in_valid, bus.res_valid, bus.res_last, bus.err};
    n_vec++;
    if (fl !== 9'b101000000) begin
      n_mis++; $display("FAIL reset_flags_in_rst: got %b expected %b", fl, 9'b101000000);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    fl = {bus.cmd_ready, bus.ld_ready, bus.host_own, bus.a_wr_en, bus.b_wr_en,
          bus.tpu_in_valid, bus.res_valid, bus.res_last, bus.err};
    n_vec++;
    if (fl !== 9'b101000000) begin
      n_mis++; $display("FAIL reset_flags: got %b expected %b", fl, 9'b101000000);
    end
    n_vec++;
    if ({bus.tpu_K, bus.tpu_M, bus.tpu_N, bus.c_index, bus.a_index} !== 56'd0 || bus.res_data !== 128'd0) begin
      n_mis++; $display("FAIL reset_values: got dims %h c_index %h a_index %h res_data %h expected all zero",
                        {bus.tpu_K, bus.tpu_M, bus.tpu_N}, bus.c_index, bus.a_index, bus.res_data);
    end
  endtask

  // T1: K=4 load with a one-cycle gap, then a single launch pulse.
  task automatic test_load;
    logic [31:0] a_vec [0:3];
    logic [31:0] b_vec [0:3];
    bit slot_v [0:4];
    int beat;
    bit ok;
    a_vec = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
    b_vec = '{32'h11121314, 32'h15161718, 32'h191a1b1c, 32'h1d1e1f20};
    slot_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bus.res_ready = 1'b1;
    send_cmd(8'd4, 8'd4, 8'd4);
    #1;
    n_vec++;
    if ({bus.ld_ready, bus.cmd_ready} !== 2'b10 || bus.tpu_K !== 8'd4) begin
      n_mis++; $display("FAIL load_enter: got ld_ready/cmd_ready %b tpu_K %0d expected 10 / 4",
                        {bus.ld_ready, bus.cmd_ready}, bus.tpu_K);
    end
    beat = 0;
    for (int s = 0; s < 5; s++) begin
      bus.ld_valid = slot_v[s];
      bus.ld_a = slot_v[s] ? a_vec[beat] : 32'hdeadbeef;
      bus.ld_b = slot_v[s] ? b_vec[beat] : 32'hdeadbeef;
      #1;
      n_vec++;
      if (slot_v[s]) begin
        if ({bus.a_wr_en, bus.b_wr_en} !== 2'b11 || bus.a_index !== 16'(beat) || bus.b_index !== 16'(beat) ||
            bus.a_data_in !== a_vec[beat] || bus.b_data_in !== b_vec[beat]) begin
          n_mis++; $display("FAIL load_write%0d: got en %b idx %0d/%0d data %h/%h expected 11 idx %0d data %h/%h",
                            beat, {bus.a_wr_en, bus.b_wr_en}, bus.a_index, bus.b_index,
                            bus.a_data_in, bus.b_data_in, beat, a_vec[beat], b_vec[beat]);
        end
        beat++;
      end else begin
        if ({bus.a_wr_en, bus.b_wr_en, bus.ld_ready} !== 3'b001) begin
          n_mis++; $display("FAIL load_gap: got en/ld_ready %b expected 001", {bus.a_wr_en, bus.b_wr_en, bus.ld_ready});
        end
      end
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    #1;
    n_vec++;
    if ({bus.tpu_in_valid, bus.host_own, bus.ld_ready, bus.a_wr_en} !== 4'b1000) begin
      n_mis++; $display("FAIL launch_pulse: got inv/own/ld_ready/wr %b expected 1000",
                        {bus.tpu_in_valid, bus.host_own, bus.ld_ready, bus.a_wr_en});
    end
    @(negedge clk); #1;
    n_vec++;
    if ({bus.tpu_in_valid, bus.host_own} !== 2'b00) begin
      n_mis++; $display("FAIL launch_once: got inv/own %b expected 00", {bus.tpu_in_valid, bus.host_own});
    end
    wait_idle(ok);
    n_vec++;
    if (!ok) begin
      n_mis++; $display("FAIL load_drain: got no return to idle expected idle within 200 cycles");
    end
  endtask

  // T2: full flow, rows every second cycle with res_ready held high.
  task automatic test_full_flow;
    bit ok;
    bit ev;
    exp_row[0] = {32'd4,  32'd8,  32'd12, 32'd16};
    exp_row[1] = {32'd8,  32'd16, 32'd24, 32'd32};
    exp_row[2] = {32'd12, 32'd24, 32'd36, 32'd48};
    exp_row[3] = {32'd16, 32'd32, 32'd48, 32'd64};
    bus.res_ready = 1'b1;
    send_cmd(8'd4, 8'd2, 8'd3);
    #1;
    n_vec++;
    if ({bus.tpu_K, bus.tpu_M, bus.tpu_N} !== {8'd4, 8'd2, 8'd3}) begin
      n_mis++; $display("FAIL flow_dims: got %h expected %h", {bus.tpu_K, bus.tpu_M, bus.tpu_N}, {8'd4, 8'd2, 8'd3});
    end
    load_beats(4, 32'h01020304, 32'h01020304);
    wait_res(ok);
    n_vec++;
    if (!ok || bus.res_data !== exp_row[0] || bus.res_last !== 1'b0) begin
      n_mis++; $display("FAIL flow_row0: got ok %0d data %h last %b expected data %h last 0",
                        ok, bus.res_data, bus.res_last, exp_row[0]);
    end
    for (int c = 1; c < 8; c++) begin
      @(negedge clk); #1;
      ev = ((c % 2) == 0) && (c <= 6);
      n_vec++;
      if (bus.res_valid !== ev) begin
        n_mis++; $display("FAIL flow_valid_c%0d: got %b expected %b", c, bus.res_valid, ev);
      end
      if (ev) begin
        n_vec++;
        if (bus.res_data !== exp_row[c/2] || bus.res_last !== (c == 6)) begin
          n_mis++; $display("FAIL flow_row%0d: got data %h last %b expected data %h last %b",
                            c/2, bus.res_data, bus.res_last, exp_row[c/2], (c == 6));
        end
      end
    end
    n_vec++;
    if ({bus.cmd_ready, bus.host_own} !== 2'b11) begin
      n_mis++; $display("FAIL flow_idle: got cmd_ready/own %b expected 11", {bus.cmd_ready, bus.host_own});
    end
  endtask

  // T3: back-pressure on row 1 for 5 cycles.
  task automatic test_backpressure;
    bit ok;
    bus.res_ready = 1'b1;
    send_cmd(8'd4, 8'd4, 8'd4);
    load_beats(4, 32'h01020304, 32'h01020304);
    wait_res(ok);
    n_vec++;
    if (!ok || bus.res_data !== exp_row[0]) begin
      n_mis++; $display("FAIL bp_row0: got ok %0d data %h expected %h", ok, bus.res_data, exp_row[0]);
    end
    @(negedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      if (h != 0) @(negedge clk);
      #1;
      n_vec++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp_row[1] || bus.res_last !== 1'b0) begin
        n_mis++; $display("FAIL bp_hold%0d: got valid %b data %h last %b expected 1 %h 0",
                          h, bus.res_valid, bus.res_data, bus.res_last, exp_row[1]);
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (bus.res_valid !== 1'b0) begin
      n_mis++; $display("FAIL bp_gap: got valid %b expected 0", bus.res_valid);
    end
    @(negedge clk); #1;
    n_vec++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== exp_row[2] || bus.res_last !== 1'b0) begin
      n_mis++; $display("FAIL bp_row2: got valid %b data %h last %b expected 1 %h 0",
                        bus.res_valid, bus.res_data, bus.res_last, exp_row[2]);
    end
    @(negedge clk);
    @(negedge clk); #1;
    n_vec++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== exp_row[3] || bus.res_last !== 1'b1) begin
      n_mis++; $display("FAIL bp_row3: got valid %b data %h last %b expected 1 %h 1",
                        bus.res_valid, bus.res_data, bus.res_last, exp_row[3]);
    end
    @(negedge clk); #1;
    n_vec++;
    if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin
      n_mis++; $display("FAIL bp_idle: got cmd_ready/valid %b expected 10", {bus.cmd_ready, bus.res_valid});
    end
  endtask

  // T4: K=0 command is rejected with a one-cycle err pulse.
  task automatic test_k_zero;
    int wr0;
    int inv0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_k = 8'd0;
    bus.cmd_m = 8'd1;
    bus.cmd_n = 8'd1;
    #1;
    wr0 = wr_cnt;
    inv0 = inv_cnt;
    n_vec++;
    if (bus.cmd_ready !== 1'b1) begin
      n_mis++; $display("FAIL k0_ready: got %b expected 1", bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    n_vec++;
    if ({bus.err, bus.cmd_ready, bus.ld_ready} !== 3'b110) begin
      n_mis++; $display("FAIL k0_err: got err/cmd_ready/ld_ready %b expected 110", {bus.err, bus.cmd_ready, bus.ld_ready});
    end
    @(negedge clk); #1;
    n_vec++;
    if ({bus.err, bus.cmd_ready} !== 2'b01) begin
      n_mis++; $display("FAIL k0_pulse: got err/cmd_ready %b expected 01", {bus.err, bus.cmd_ready});
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (wr_cnt != wr0 || inv_cnt != inv0) begin
      n_mis++; $display("FAIL k0_side: got writes %0d launches %0d expected 0 0", wr_cnt - wr0, inv_cnt - inv0);
    end
  endtask

  // T5: busy never rises, err after 16 cycles in WAITB.
  task automatic test_timeout;
    tpu_en = 1'b0;
    send_cmd(8'd1, 8'd1, 8'd1);
    load_beats(1, 32'h7f7f7f7f, 32'h01010101);
    #1;
    n_vec++;
    if (bus.tpu_in_valid !== 1'b1) begin
      n_mis++; $display("FAIL to_launch: got %b expected 1", bus.tpu_in_valid);
    end
    for (int w = 0; w < 16; w++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({bus.host_own, bus.err, bus.cmd_ready} !== 3'b000) begin
        n_mis++; $display("FAIL to_wait%0d: got own/err/cmd_ready %b expected 000", w, {bus.host_own, bus.err, bus.cmd_ready});
      end
    end
    @(negedge clk); #1;
    n_vec++;
    if ({bus.host_own, bus.err, bus.cmd_ready} !== 3'b111) begin
      n_mis++; $display("FAIL to_err: got own/err/cmd_ready %b expected 111", {bus.host_own, bus.err, bus.cmd_ready});
    end
    @(negedge clk); #1;
    n_vec++;
    if (bus.err !== 1'b0) begin
      n_mis++; $display("FAIL to_pulse: got err %b expected 0", bus.err);
    end
    tpu_en = 1'b1;
  endtask

  // T6: reset during LOAD at kc=2, then a fresh K=2 command completes.
  task automatic test_reset_mid_load;
    logic [8:0] fl;
    bit ok;
    bus.res_ready = 1'b1;
    send_cmd(8'd4, 8'd4, 8'd4);
    load_beats(2, 32'h55555555, 32'h55555555);
    rst = 1'b1;
    bus.ld_valid = 1'b1;
    @(negedge clk); #1;
    fl = {bus.cmd_ready, bus.ld_ready, bus.host_own, bus.a_wr_en, bus.b_wr_en,
          bus.tpu_in_valid, bus.res_valid, bus.res_last, bus.err};
    n_vec++;
    if (fl !== 9'b101000000 || bus.tpu_K !== 8'd0 || bus.a_index !== 16'd0) begin
      n_mis++; $display("FAIL rst_mid: got flags %b tpu_K %0d a_index %0d expected 101000000 0 0", fl, bus.tpu_K, bus.a_index);
    end
    rst = 1'b0;
    bus.ld_valid = 1'b0;
    exp_row[0] = {32'd2, 32'd4,  32'd6,  32'd8};
    exp_row[1] = {32'd4, 32'd8,  32'd12, 32'd16};
    exp_row[2] = {32'd6, 32'd12, 32'd18, 32'd24};
    exp_row[3] = {32'd8, 32'd16, 32'd24, 32'd32};
    send_cmd(8'd2, 8'd4, 8'd4);
    load_beats(2, 32'h01020304, 32'h01020304);
    wait_res(ok);
    n_vec++;
    if (!ok || bus.res_data !== exp_row[0] || bus.res_last !== 1'b0) begin
      n_mis++; $display("FAIL rst_row0: got ok %0d data %h last %b expected %h 0", ok, bus.res_data, bus.res_last, exp_row[0]);
    end
    for (int r = 1; r < 4; r++) begin
      @(negedge clk);
      @(negedge clk); #1;
      n_vec++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp_row[r] || bus.res_last !== (r == 3)) begin
        n_mis++; $display("FAIL rst_row%0d: got valid %b data %h last %b expected 1 %h %b",
                          r, bus.res_valid, bus.res_data, bus.res_last, exp_row[r], (r == 3));
      end
    end
    @(negedge clk); #1;
    n_vec++;
    if (bus.cmd_ready !== 1'b1) begin
      n_mis++; $display("FAIL rst_idle: got cmd_ready %b expected 1", bus.cmd_ready);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_k = 8'd0;
    bus.cmd_m = 8'd0;
    bus.cmd_n = 8'd0;
    bus.ld_valid = 1'b0;
    bus.ld_a = 32'd0;
    bus.ld_b = 32'd0;
    bus.res_ready = 1'b0;
    test_reset();
    test_load();
    test_full_flow();
    test_backpressure();
    test_k_zero();
    test_timeout();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
